ofs_plat_pcie_tlp_rd_tag_tracker: RTL and testbench
===================================================

// Module: ofs_plat_pcie_tlp_rd_tag_tracker
// PURPOSE
//  Allocates PCIe tags for outbound MRd requests and tracks each read until its final completion.
//  Sits on the host-channel RX side, downstream of the FIM gasket that decodes t_ofs_plat_pcie_hdr.
//  Per-tag remaining-dword count is maintained; the block reports tag retirement and protocol errors
//  (unexpected tag, overrun, data-less Cpl) to the read-response reorder logic.
// PARAMETERS
//  NUM_TAGS    64                   outstanding read tags supported (power of 2, 2..512)
//  TAG_WIDTH   $clog2(NUM_TAGS)     width of internal tag index
// PORTS
//  clk              in   1          single clock
//  reset            in   1          synchronous, active-high reset
//  req_valid        in   1          upstream requests a tag for a new MRd
//  req_ready        out  1          a free tag exists; transfer on req_valid && req_ready
//  req_length       in   10         MRd length in DW (t_ofs_plat_pcie_hdr_length, 0 == 1024)
//  req_tag          out  TAG_WIDTH  tag granted; valid whenever req_ready=1
//  cpl_valid        in   1          completion header from gasket
//  cpl_ready        out  1          always 1 after reset (block never back-pressures)
//  cpl_hdr          in   t_ofs_plat_pcie_hdr  decoded header (u.cpl view used)
//  done_valid       out  1          one-cycle pulse: a completion was processed
//  done_tag         out  TAG_WIDTH  tag of processed completion
//  done_last        out  1          tag retired (final completion)
//  done_err         out  1          protocol error on this completion
//  num_busy         out  TAG_WIDTH+1  count of allocated tags
// BEHAVIOUR
//  - Reset: all tags free, remaining=0, req_ready=0 and cpl_ready=0 during reset; done_* = 0,
//    num_busy=0. Reset mid-operation discards all outstanding tags; late completions then error.
//  - Allocation: req_tag = lowest-index free tag (combinational); req_ready = !reset && any free.
//    On transfer: busy[t]<=1, remain[t]<=len_to_dw(req_length) (11 bits, 0 -> 1024).
//  - Completion accepted when cpl_valid && is_completion(fmttype); other fmttypes and is_irq
//    headers are ignored (no done pulse). t = cpl.tag[TAG_WIDTH-1:0]; L = len_to_dw(length).
//  - Classification (all registered, done_* valid exactly 1 cycle after acceptance):
//    * tag[9:TAG_WIDTH] != 0 or !busy[t]        -> err=1, last=0, state untouched
//    * fmttype == CPL (no data)                 -> err=1, last=1, tag freed
//    * CPLD, L > remain[t]                      -> err=1, last=1, tag freed
//    * CPLD, dm_encoded                         -> remain-=L; last=fc; err = fc && (remain-L != 0)
//    * CPLD, PU encoded                         -> remain-=L; last=(remain-L == 0); err=0
//    On last: busy[t]<=0 at the same edge done_valid rises; tag reallocatable that cycle.
//  - Simultaneous alloc + completion: allowed same cycle. Retiring tag still reads busy, so it is
//    never the one granted; num_busy updates by +1, -1 or net 0.
//  - Back-to-back completions to the same tag every cycle must accumulate correctly
//    (single-cycle read-modify-write of remain[t]; no bypass hazard).
//  - num_busy never exceeds NUM_TAGS; req_ready=0 when num_busy==NUM_TAGS.
// STRUCTURE
//  - Add to ofs_plat_pcie_tlp_hdr_pkg: function ofs_plat_pcie_func_len_to_dw(length) -> [10:0]
//    (0 -> 1024), and ofs_plat_pcie_func_is_cpld(fmttype).
//  - Sub-module ofs_plat_pcie_tag_free_finder: NUM_TAGS-wide busy vector -> lowest free index
//    + any_free (combinational priority encoder).
//  - busy[] in flops; remain[] as flop array (NUM_TAGS x 11).
// TESTING
//  1. Reset, req_valid with req_length=16 four times -> req_tag 0,1,2,3; num_busy=4.
//  2. Tag 2 len 16: PU CplD len 8 then len 8 -> done_last 0 then 1, err 0; next alloc gets tag 2.
//  3. DM CplD tag 0 len 16 fc=1 -> done_last=1, err=0; same with len 8 fc=1 -> last=1, err=1.
//  4. CplD to free tag 5, and tag=0x3FF with NUM_TAGS=64 -> done_err=1, last=0, num_busy unchanged.
//  5. Fill all 64 tags -> req_ready=0; final CplD for tag 17 and req_valid same cycle -> grant
//     tag 17 the following cycle only, num_busy stays 64.
//  6. Alloc req_length=0, 8 CplDs len 128 -> last only on 8th; then reset mid-flight -> num_busy 0.

Source files
------------

// File: rtl/ofs_plat_pcie_tlp_hdr_pkg.sv
// ofs_plat_pcie_tlp_hdr_pkg: decoded PCIe TLP header types and helper functions.
//   t_ofs_plat_pcie_hdr is the gasket-decoded header: fmttype, length (DW, 0 == 1024),
//   is_irq and a union whose cpl view carries tag, dm_encoded and fc (final completion).
package ofs_plat_pcie_tlp_hdr_pkg;

    typedef logic [9:0] t_ofs_plat_pcie_hdr_length;
    typedef logic [9:0] t_ofs_plat_pcie_hdr_tag;

    typedef enum logic [7:0] {
        OFS_PLAT_PCIE_FMTTYPE_MEM_READ32  = 8'h00,
        OFS_PLAT_PCIE_FMTTYPE_MEM_READ64  = 8'h20,
        OFS_PLAT_PCIE_FMTTYPE_MSG         = 8'h30,
        OFS_PLAT_PCIE_FMTTYPE_MEM_WRITE32 = 8'h40,
        OFS_PLAT_PCIE_FMTTYPE_MEM_WRITE64 = 8'h60,
        OFS_PLAT_PCIE_FMTTYPE_CPL         = 8'h0a,
        OFS_PLAT_PCIE_FMTTYPE_CPLD        = 8'h4a
    } t_ofs_plat_pcie_fmttype;

    typedef struct packed {
        logic [15:0]            requester_id;
        t_ofs_plat_pcie_hdr_tag tag;
        logic [15:0]            completer_id;
        logic [11:0]            byte_count;
        logic [6:0]             lower_addr;
        // dm_encoded: data-mover style completion, fc marks the final packet of the read
        logic                   dm_encoded;
        logic                   fc;
    } t_ofs_plat_pcie_hdr_cpl;

    localparam int OFS_PLAT_PCIE_HDR_U_W = $bits(t_ofs_plat_pcie_hdr_cpl);

    typedef union packed {
        t_ofs_plat_pcie_hdr_cpl           cpl;
        logic [OFS_PLAT_PCIE_HDR_U_W-1:0] raw;
    } t_ofs_plat_pcie_hdr_u;

    typedef struct packed {
        t_ofs_plat_pcie_fmttype    fmttype;
        t_ofs_plat_pcie_hdr_length length;
        logic                      is_irq;
        t_ofs_plat_pcie_hdr_u      u;
    } t_ofs_plat_pcie_hdr;

    function automatic logic [10:0] ofs_plat_pcie_func_len_to_dw(input t_ofs_plat_pcie_hdr_length length);
        return (length == '0) ? 11'd1024 : {1'b0, length};
    endfunction

    function automatic logic ofs_plat_pcie_func_is_cpld(input t_ofs_plat_pcie_fmttype fmttype);
        return fmttype == OFS_PLAT_PCIE_FMTTYPE_CPLD;
    endfunction

    function automatic logic ofs_plat_pcie_func_is_completion(input t_ofs_plat_pcie_fmttype fmttype);
        return (fmttype == OFS_PLAT_PCIE_FMTTYPE_CPL) || (fmttype == OFS_PLAT_PCIE_FMTTYPE_CPLD);
    endfunction

endpackage

// File: rtl/ofs_plat_pcie_tag_free_finder.sv
// ofs_plat_pcie_tag_free_finder: lowest-index free tag from a busy vector.
//   busy_i      in   NUM_TAGS   1 = tag allocated
//   free_tag_o  out  TAG_WIDTH  lowest index with busy_i == 0 (0 when none free)
//   any_free_o  out  1          at least one tag free
module ofs_plat_pcie_tag_free_finder #(
    parameter int NUM_TAGS  = 64,
    parameter int TAG_WIDTH = $clog2(NUM_TAGS)
) (
    input  logic [NUM_TAGS-1:0]  busy_i,
    output logic [TAG_WIDTH-1:0] free_tag_o,
    output logic                 any_free_o
);

    always_comb begin
        free_tag_o = '0;
        // Scan downward so the lowest free index wins
        for (int i = NUM_TAGS - 1; i >= 0; i--)
            if (!busy_i[i]) free_tag_o = i[TAG_WIDTH-1:0];
        any_free_o = ~&busy_i;
    end

endmodule

// File: rtl/ofs_plat_pcie_tlp_rd_tag_tracker.sv
// ofs_plat_pcie_tlp_rd_tag_tracker: allocates MRd tags and tracks remaining DWs to final completion.
//   req_valid/req_ready/req_length/req_tag  tag allocation handshake (lowest free tag granted)
//   cpl_valid/cpl_ready/cpl_hdr             completion headers from the gasket, never stalled
//   done_valid/done_tag/done_last/done_err  registered per-completion result, one cycle later
//   num_busy                                number of allocated tags
module ofs_plat_pcie_tlp_rd_tag_tracker
    import ofs_plat_pcie_tlp_hdr_pkg::*;
#(
    parameter int NUM_TAGS  = 64,
    parameter int TAG_WIDTH = $clog2(NUM_TAGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [9:0]            req_length,
    output logic [TAG_WIDTH-1:0]  req_tag,
    input  logic                  cpl_valid,
    output logic                  cpl_ready,
    input  t_ofs_plat_pcie_hdr    cpl_hdr,
    output logic                  done_valid,
    output logic [TAG_WIDTH-1:0]  done_tag,
    output logic                  done_last,
    output logic                  done_err,
    output logic [TAG_WIDTH:0]    num_busy
);

    logic [NUM_TAGS-1:0]  busy_q, busy_d;
    logic [10:0]          remain_q [NUM_TAGS];
    logic [TAG_WIDTH:0]   num_busy_q, num_busy_d;
    logic                 done_valid_q, done_last_q, done_err_q;
    logic [TAG_WIDTH-1:0] done_tag_q;

    logic                 any_free, alloc, cpl_acc, tag_ok, retire;
    logic                 last_d, err_d, upd_rem;
    logic [TAG_WIDTH-1:0] free_tag, cpl_tag;
    logic [10:0]          cpl_len, cpl_rem, rem_after;
    logic                 unused_hdr;

    ofs_plat_pcie_tag_free_finder #(
        .NUM_TAGS  (NUM_TAGS),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_free (
        .busy_i     (busy_q),
        .free_tag_o (free_tag),
        .any_free_o (any_free)
    );

    assign unused_hdr = ^cpl_hdr;

    assign req_ready = !reset && any_free;
    assign req_tag   = free_tag;
    assign cpl_ready = !reset;
    assign alloc     = req_valid && req_ready;

    assign cpl_acc   = cpl_valid && !reset && !cpl_hdr.is_irq &&
                       ofs_plat_pcie_func_is_completion(cpl_hdr.fmttype);
    assign cpl_tag   = cpl_hdr.u.cpl.tag[TAG_WIDTH-1:0];
    // Tag bits above the index must be zero, otherwise the completion aliases no real tag
    assign tag_ok    = ((cpl_hdr.u.cpl.tag >> TAG_WIDTH) == '0) && busy_q[cpl_tag];
    assign cpl_len   = ofs_plat_pcie_func_len_to_dw(cpl_hdr.length);
    assign cpl_rem   = remain_q[cpl_tag];
    assign rem_after = cpl_rem - cpl_len;

    always_comb begin
        upd_rem = 1'b0;
        last_d  = 1'b0;
        err_d   = 1'b0;
        if (!tag_ok) begin
            err_d = 1'b1;
        end else if (!ofs_plat_pcie_func_is_cpld(cpl_hdr.fmttype) || (cpl_len > cpl_rem)) begin
            err_d  = 1'b1;
            last_d = 1'b1;
        end else if (cpl_hdr.u.cpl.dm_encoded) begin
            upd_rem = 1'b1;
            last_d  = cpl_hdr.u.cpl.fc;
            err_d   = cpl_hdr.u.cpl.fc && (rem_after != '0);
        end else begin
            upd_rem = 1'b1;
            last_d  = (rem_after == '0);
        end
    end

    // A granted tag is free and a retiring tag is busy, so the two indices never collide
    assign retire = cpl_acc && last_d;

    always_comb begin
        busy_d = busy_q;
        if (alloc) busy_d[free_tag] = 1'b1;
        if (retire) busy_d[cpl_tag] = 1'b0;
        num_busy_d = num_busy_q + (TAG_WIDTH+1)'(alloc) - (TAG_WIDTH+1)'(retire);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q       <= '0;
            num_busy_q   <= '0;
            done_valid_q <= 1'b0;
            done_tag_q   <= '0;
            done_last_q  <= 1'b0;
            done_err_q   <= 1'b0;
            for (int i = 0; i < NUM_TAGS; i++) remain_q[i] <= '0;
        end else begin
            busy_q       <= busy_d;
            num_busy_q   <= num_busy_d;
            done_valid_q <= cpl_acc;
            done_tag_q   <= cpl_tag;
            done_last_q  <= cpl_acc && last_d;
            done_err_q   <= cpl_acc && err_d;
            if (alloc) remain_q[free_tag] <= ofs_plat_pcie_func_len_to_dw(req_length);
            if (cpl_acc && upd_rem) remain_q[cpl_tag] <= rem_after;
        end
    end

    assign done_valid = done_valid_q;
    assign done_tag   = done_tag_q;
    assign done_last  = done_last_q;
    assign done_err   = done_err_q;
    assign num_busy   = num_busy_q;

endmodule

// File: tb/tb_ofs_plat_pcie_tlp_rd_tag_tracker.sv
// tb_ofs_plat_pcie_tlp_rd_tag_tracker: directed scenarios plus random traffic against a tag/DW-count model.
module tb_ofs_plat_pcie_tlp_rd_tag_tracker;
    import ofs_plat_pcie_tlp_hdr_pkg::*;

    localparam int NT = 64;
    localparam int TW = 6;

    logic               clk = 1'b0;
    logic               reset;
    logic               req_valid, req_ready, cpl_valid, cpl_ready;
    logic [9:0]         req_length;
    logic [TW-1:0]      req_tag, done_tag;
    t_ofs_plat_pcie_hdr cpl_hdr;
    logic               done_valid, done_last, done_err;
    logic [TW:0]        num_busy;

    int checks = 0;
    int errors = 0;
    bit mbusy [NT];
    int mrem  [NT];

    ofs_plat_pcie_tlp_rd_tag_tracker #(.NUM_TAGS(NT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_length (req_length),
        .req_tag    (req_tag),
        .cpl_valid  (cpl_valid),
        .cpl_ready  (cpl_ready),
        .cpl_hdr    (cpl_hdr),
        .done_valid (done_valid),
        .done_tag   (done_tag),
        .done_last  (done_last),
        .done_err   (done_err),
        .num_busy   (num_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic t_ofs_plat_pcie_hdr mk(input t_ofs_plat_pcie_fmttype f, input int len,
                                               input int tag, input bit dm, input bit fc, input bit irq);
        t_ofs_plat_pcie_hdr h;
        h = '0;
        h.fmttype = f;
        h.length = 10'(len);
        h.is_irq = irq;
        h.u.cpl.tag = 10'(tag);
        h.u.cpl.dm_encoded = dm;
        h.u.cpl.fc = fc;
        return h;
    endfunction

    function automatic int dw(input int len);
        return (len == 0) ? 1024 : len;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < NT; i++) if (!mbusy[i]) return i;
        return -1;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NT; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    // One clock: drive inputs, check combinational outputs, advance, check done_* against the model.
    // granted returns the DUT's req_tag when it offered one, else -1.
    task automatic cycle(input bit rv, input int rlen, input bit cv, input t_ofs_plat_pcie_hdr h,
                         output int granted);
        int ft, t, l;
        bit ev, el, ee;
        req_valid = rv;
        req_length = 10'(rlen);
        cpl_valid = cv;
        cpl_hdr = h;
        #1;
        ft = m_free();
        granted = req_ready ? int'(req_tag) : -1;
        chk("req_ready", int'(req_ready), int'(ft >= 0));
        if (ft >= 0) chk("req_tag", int'(req_tag), ft);
        chk("num_busy", int'(num_busy), m_count());
        chk("cpl_ready", int'(cpl_ready), 1);
        ev = cv && !h.is_irq && (h.fmttype == OFS_PLAT_PCIE_FMTTYPE_CPL ||
                                 h.fmttype == OFS_PLAT_PCIE_FMTTYPE_CPLD);
        el = 1'b0;
        ee = 1'b0;
        t = int'(h.u.cpl.tag);
        l = dw(int'(h.length));
        if (ev) begin
            if (t >= NT || !mbusy[t]) begin
                ee = 1'b1;
            end else if (h.fmttype == OFS_PLAT_PCIE_FMTTYPE_CPL || l > mrem[t]) begin
                ee = 1'b1;
                el = 1'b1;
            end else begin
                mrem[t] -= l;
                el = h.u.cpl.dm_encoded ? h.u.cpl.fc : (mrem[t] == 0);
                ee = h.u.cpl.dm_encoded && h.u.cpl.fc && (mrem[t] != 0);
            end
            if (el) mbusy[t] = 1'b0;
        end
        if (rv && ft >= 0) begin
            mbusy[ft] = 1'b1;
            mrem[ft] = dw(rlen);
        end
        @(posedge clk);
        #1;
        chk("done_valid", int'(done_valid), int'(ev));
        if (ev) begin
            chk("done_tag", int'(done_tag), t % NT);
            chk("done_last", int'(done_last), int'(el));
            chk("done_err", int'(done_err), int'(ee));
        end
    endtask

    // Reset with a request and a plausible completion pending; neither may take effect.
    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b1;
        req_length = 10'd4;
        cpl_valid = 1'b1;
        cpl_hdr = mk(OFS_PLAT_PCIE_FMTTYPE_CPLD, 4, 0, 0, 0, 0);
        #1;
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_cpl_ready", int'(cpl_ready), 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_done_valid", int'(done_valid), 0);
        chk("rst_done_last", int'(done_last), 0);
        chk("rst_done_err", int'(done_err), 0);
        chk("rst_num_busy", int'(num_busy), 0);
        for (int i = 0; i < NT; i++) begin
            mbusy[i] = 1'b0;
            mrem[i] = 0;
        end
        reset = 1'b0;
        req_valid = 1'b0;
        cpl_valid = 1'b0;
    endtask

    initial begin
        t_ofs_plat_pcie_hdr idle, h;
        int g;
        idle = mk(OFS_PLAT_PCIE_FMTTYPE_MEM_READ32, 0, 0, 0, 0, 0);
        do_reset();

        // Four allocations of 16 DW take tags 0..3
        for (int i = 0; i < 4; i++) begin
            cycle(1, 16, 0, idle, g);
            chk("t1_tag", g, i);
        end
        cycle(0, 0, 0, idle, g);
        chk("t1_busy", int'(num_busy), 4);

        // PU completions on tag 2 retire it on the second; tag 2 is then granted again
        cycle(0, 0, 1, mk(OFS_PLAT_PCIE_FMTTYPE_CPLD, 8, 2, 0, 0, 0), g);
        chk("t2_last0", int'(done_last), 0);
        cycle(0, 0, 1, mk(OFS_PLAT_PCIE_FMTTYPE_CPLD, 8, 2, 0, 0, 0), g);
        chk("t2_last1", int'(done_last), 1);
        chk("t2_err", int'(done_err), 0);
        cycle(1, 16, 0, idle, g);
        chk("t2_realloc", g, 2);

        // DM completions: exact fc is clean, short fc is an error
        cycle(0, 0, 1, mk(OFS_PLAT_PCIE_FMTTYPE_CPLD, 16, 0, 1, 1, 0), g);
        chk("t3_last", int'(done_last), 1);
        chk("t3_err", int'(done_err), 0);
        cycle(0, 0, 1, mk(OFS_PLAT_PCIE_FMTTYPE_CPLD, 8, 1, 1, 1, 0), g);
        chk("t3_short_last", int'(done_last), 1);
        chk("t3_short_err", int'(done_err), 1);

        // Unexpected tags: a free one and one with high tag bits set
        cycle(0, 0, 1, mk(OFS_PLAT_PCIE_FMTTYPE_CPLD, 4, 5, 0, 0, 0), g);
        chk("t4_free_err", int'(done_err), 1);
        chk("t4_free_last", int'(done_last), 0);
        cycle(0, 0, 1, mk(OFS_PLAT_PCIE_FMTTYPE_CPLD, 4, 10'h3ff, 0, 0, 0), g);
        chk("t4_hi_err", int'(done_err), 1);
        chk("t4_hi_last", int'(done_last), 0);
        cycle(0, 0, 0, idle, g);
        chk("t4_busy", int'(num_busy), 2);

        // Full table: a retire and a request in the same cycle grant the freed tag one cycle later
        do_reset();
        for (int i = 0; i < NT; i++) cycle(1, 16, 0, idle, g);
        cycle(0, 0, 0, idle, g);
        chk("t5_full_ready", int'(req_ready), 0);
        chk("t5_full_busy", int'(num_busy), NT);
        cycle(1, 16, 1, mk(OFS_PLAT_PCIE_FMTTYPE_CPLD, 16, 17, 0, 0, 0), g);
        chk("t5_no_grant", g, -1);
        chk("t5_retire", int'(done_last), 1);
        cycle(1, 16, 0, idle, g);
        chk("t5_grant", g, 17);
        cycle(0, 0, 0, idle, g);
        chk("t5_busy", int'(num_busy), NT);

        // 1024-DW read split into eight 128-DW completions, then reset while a read is in flight
        do_reset();
        cycle(1, 0, 0, idle, g);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 1, mk(OFS_PLAT_PCIE_FMTTYPE_CPLD, 128, 0, 0, 0, 0), g);
            chk("t6_last", int'(done_last), int'(i == 7));
        end
        cycle(1, 0, 0, idle, g);
        cycle(0, 0, 1, mk(OFS_PLAT_PCIE_FMTTYPE_CPLD, 128, 0, 0, 0, 0), g);
        do_reset();
        cycle(0, 0, 1, mk(OFS_PLAT_PCIE_FMTTYPE_CPLD, 128, 0, 0, 0, 0), g);
        chk("t6_late_err", int'(done_err), 1);
        chk("t6_late_last", int'(done_last), 0);

        // Random traffic, completions biased toward busy tags
        for (int n = 0; n < 4000; n++) begin
            int t0, t, rem, l, r, rl;
            t_ofs_plat_pcie_fmttype f;
            if ($urandom_range(0, 599) == 0) do_reset();
            t0 = $urandom_range(0, NT - 1);
            t = t0;
            for (int k = 0; k < NT; k++)
                if (mbusy[(t0 + k) % NT]) begin
                    t = (t0 + k) % NT;
                    break;
                end
            if ($urandom_range(0, 7) == 0) t = $urandom_range(0, 1023);
            rem = (t < NT && mbusy[t]) ? mrem[t] : 16;
            if (rem < 1) rem = 1;
            r = $urandom_range(0, 7);
            l = (r == 0) ? ((rem < 1024) ? rem + 1 : rem) : (r < 4) ? rem : $urandom_range(1, rem);
            r = $urandom_range(0, 15);
            f = (r == 0) ? OFS_PLAT_PCIE_FMTTYPE_CPL :
                (r == 1) ? OFS_PLAT_PCIE_FMTTYPE_MEM_READ32 :
                (r == 2) ? OFS_PLAT_PCIE_FMTTYPE_MSG : OFS_PLAT_PCIE_FMTTYPE_CPLD;
            h = mk(f, l, t, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 31) == 0);
            rl = ($urandom_range(0, 31) == 0) ? 0 : $urandom_range(1, 32);
            cycle($urandom_range(0, 1) == 1, rl, $urandom_range(0, 3) != 0, h, g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
